// File: rtl/checker_mc.sv
// checker_mc: CSR-controlled check dispatcher for NCHAN backends.
// A CSR file holds the mode, check address, watchdog limit and interrupt
// enables. A start command launches one run on the backend selected by MODE.
// The run is tracked by a watchdog, a cycle counter and a run counter, and
// finishes with a done, timeout or abort outcome recorded in STATUS.
module checker_mc #(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         MODE_W   = 2,
  parameter int         ADDR_W   = 64
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [13:0]                 csr_a,
  input  logic                        csr_we,
  input  logic [31:0]                 csr_di,
  output logic [31:0]                 csr_do,
  output logic                        irq,
  output logic [MODE_W-1:0]           cmode,
  output logic [(1<<MODE_W)-1:0]      cstart,
  output logic [(1<<MODE_W)-1:0]      cabort,
  output logic [ADDR_W-1:0]           caddr,
  input  logic [(1<<MODE_W)-1:0]      cend,
  input  logic [8*(1<<MODE_W)-1:0]    cctrl
);

  localparam int NCHAN = 1 << MODE_W;

  // Register offsets within the bank (csr_a[3:0]).
  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_MODE    = 4'd1;
  localparam logic [3:0] REG_ADDR_LO = 4'd2;
  localparam logic [3:0] REG_ADDR_HI = 4'd3;
  localparam logic [3:0] REG_TIMEOUT = 4'd4;
  localparam logic [3:0] REG_STATUS  = 4'd5;
  localparam logic [3:0] REG_IRQEN   = 4'd6;
  localparam logic [3:0] REG_CYCLES  = 4'd7;
  localparam logic [3:0] REG_RUNS    = 4'd8;

  // The encoding is visible to software through CTRL[1:0].
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Configuration registers.
  logic [MODE_W-1:0] mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       timeout_reg;
  logic [2:0]        irqen_reg;

  // Status and run bookkeeping.
  logic [7:0]        result_reg;
  logic              done_flag;
  logic              tmo_flag;
  logic              abt_flag;
  logic [31:0]       cycles_reg;
  logic [31:0]       runs_reg;
  logic              abort_pend;

  // Decoded bus access.
  logic              sel;
  logic [3:0]        reg_idx;
  logic              wr;
  logic              ctrl_wr;
  logic              start_wr;
  logic              abort_wr;
  logic              busy;

  // Run event qualifiers.
  logic              cend_hit;
  logic              tmo_hit;
  logic              abort_hit;
  logic [31:0]       cyc_inc;
  logic [7:0]        res_sel;
  logic [NCHAN-1:0]  onehot_mode;
  logic [NCHAN-1:0]  onehot_cmode;

  // FSM decisions consumed by the bookkeeping register block.
  logic              do_start;
  logic              do_end;
  logic              do_abort;
  logic              do_tmo;

  logic [31:0]       rd_data;
  logic [31:0]       addr_hi_rd;

  // Address bits between the bank select and the register offset carry no meaning.
  logic              unused_csr_a;
  assign unused_csr_a = ^csr_a[9:4];

  assign sel      = (csr_a[13:10] == csr_addr);
  assign reg_idx  = csr_a[3:0];
  assign wr       = sel && csr_we;
  assign ctrl_wr  = wr && (reg_idx == REG_CTRL);
  assign start_wr = ctrl_wr && csr_di[0];
  assign abort_wr = ctrl_wr && csr_di[1];
  assign busy     = (state != IDLE);

  assign onehot_mode  = NCHAN'(1) << mode_reg;
  assign onehot_cmode = NCHAN'(1) << cmode;

  // A run only listens to the backend it was launched on.
  assign cend_hit  = cend[cmode];
  // Abort requested in START is held one cycle and acted on in the first RUN cycle.
  assign abort_hit = abort_wr || abort_pend;
  // Cycle count including the current RUN cycle, saturating at all ones.
  assign cyc_inc   = (cycles_reg == 32'hFFFF_FFFF) ? cycles_reg : cycles_reg + 32'd1;
  // The watchdog fires in the RUN cycle that brings CYCLES up to TIMEOUT.
  assign tmo_hit   = (timeout_reg != 32'd0) && (cyc_inc == timeout_reg);

  // Pick the result byte belonging to the active backend.
  always_comb begin
    res_sel = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (cmode == MODE_W'(i)) begin
        res_sel = cctrl[8*i +: 8];
      end
    end
  end

  // Run state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; completion beats abort, abort beats the watchdog.
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_end     = 1'b0;
    do_abort   = 1'b0;
    do_tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr && !abort_wr) begin
          state_next = START;
          do_start   = 1'b1;
        end
      end
      START: begin
        state_next = RUN;
      end
      RUN: begin
        if (cend_hit) begin
          state_next = DONE;
          do_end     = 1'b1;
        end else if (abort_hit) begin
          state_next = DONE;
          do_abort   = 1'b1;
        end else if (tmo_hit) begin
          state_next = DONE;
          do_tmo     = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Configuration registers; run parameters are frozen while a run is active.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_reg    <= '0;
      addr_reg    <= '0;
      timeout_reg <= '0;
      irqen_reg   <= '0;
    end else begin
      if (wr && !busy) begin
        case (reg_idx)
          REG_MODE:    mode_reg              <= csr_di[MODE_W-1:0];
          REG_ADDR_LO: addr_reg[31:0]        <= csr_di;
          REG_ADDR_HI: addr_reg[ADDR_W-1:32] <= csr_di[ADDR_W-33:0];
          REG_TIMEOUT: timeout_reg           <= csr_di;
          default: ;
        endcase
      end
      if (wr && (reg_idx == REG_IRQEN)) begin
        irqen_reg <= csr_di[2:0];
      end
    end
  end

  // Backend strobes, run counters and status flags; a flag set wins over its W1C.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cstart     <= '0;
      cabort     <= '0;
      cmode      <= '0;
      caddr      <= '0;
      cycles_reg <= '0;
      runs_reg   <= '0;
      result_reg <= '0;
      done_flag  <= 1'b0;
      tmo_flag   <= 1'b0;
      abt_flag   <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      cstart     <= do_start ? onehot_mode : '0;
      cabort     <= (do_abort || do_tmo) ? onehot_cmode : '0;
      abort_pend <= (state == START) && abort_wr;

      if (do_start) begin
        cmode <= mode_reg;
        caddr <= addr_reg;
      end

      if (state == START) begin
        cycles_reg <= '0;
      end else if (state == RUN) begin
        cycles_reg <= cyc_inc;
      end

      if (wr && (reg_idx == REG_STATUS)) begin
        if (csr_di[8]) done_flag <= 1'b0;
        if (csr_di[9]) tmo_flag  <= 1'b0;
        if (csr_di[10]) abt_flag <= 1'b0;
      end

      if (do_end) begin
        result_reg <= res_sel;
        done_flag  <= 1'b1;
        runs_reg   <= runs_reg + 32'd1;
      end
      if (do_tmo) begin
        tmo_flag <= 1'b1;
      end
      if (do_abort) begin
        abt_flag <= 1'b1;
      end
    end
  end

  // Read multiplexer; unselected banks and unmapped offsets read as zero.
  always_comb begin
    rd_data    = '0;
    addr_hi_rd = '0;
    addr_hi_rd[ADDR_W-33:0] = addr_reg[ADDR_W-1:32];
    if (sel) begin
      case (reg_idx)
        REG_CTRL:    rd_data[1:0]        = state;
        REG_MODE:    rd_data[MODE_W-1:0] = mode_reg;
        REG_ADDR_LO: rd_data             = addr_reg[31:0];
        REG_ADDR_HI: rd_data             = addr_hi_rd;
        REG_TIMEOUT: rd_data             = timeout_reg;
        REG_STATUS:  rd_data[11:0]       = {busy, abt_flag, tmo_flag, done_flag, result_reg};
        REG_IRQEN:   rd_data[2:0]        = irqen_reg;
        REG_CYCLES:  rd_data             = cycles_reg;
        REG_RUNS:    rd_data             = runs_reg;
        default:     rd_data             = '0;
      endcase
    end
  end

  // Registered read data port.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_do <= '0;
    end else begin
      csr_do <= rd_data;
    end
  end

  assign irq = |({abt_flag, tmo_flag, done_flag} & irqen_reg);

endmodule

// File: tb/tb_checker_mc.sv
// Testbench for checker_mc: scenario tasks with randomized modes, addresses,
// delays and result bytes, checked against a register-level model of the
// CSR map and run outcomes.
module tb_checker_mc;

  localparam logic [3:0] BANK = 4'h0;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic [1:0]  cmode;
  logic [3:0]  cstart;
  logic [3:0]  cabort;
  logic [63:0] caddr;
  logic [3:0]  cend;
  logic [31:0] cctrl;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the software-visible state.
  logic [1:0]  m_mode;
  logic [63:0] m_addr;
  logic [31:0] m_timeout;
  logic [2:0]  m_irqen;
  logic [7:0]  m_result;
  logic        m_done, m_tmo, m_abt;
  logic [31:0] m_runs;
  logic [31:0] m_cycles;

  // Pulse monitor on the backend strobes.
  int          cstart_pulses = 0;
  int          cabort_pulses = 0;
  logic [3:0]  last_cstart = '0;
  logic [3:0]  last_cabort = '0;

  checker_mc #(.csr_addr(BANK), .MODE_W(2), .ADDR_W(64)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
    .csr_di(csr_di), .csr_do(csr_do), .irq(irq), .cmode(cmode),
    .cstart(cstart), .cabort(cabort), .caddr(caddr), .cend(cend), .cctrl(cctrl)
  );

  always #5 sys_clk = ~sys_clk;

  // Count strobe cycles on the falling edge, away from register updates.
  always @(negedge sys_clk) begin
    if (cstart != 4'd0) begin
      cstart_pulses <= cstart_pulses + 1;
      last_cstart   <= cstart;
    end
    if (cabort != 4'd0) begin
      cabort_pulses <= cabort_pulses + 1;
      last_cabort   <= cabort;
    end
  end

  function automatic logic [31:0] exp_status(input logic busy);
    return {20'd0, busy, m_abt, m_tmo, m_done, m_result};
  endfunction

  function automatic logic exp_irq();
    return |({m_abt, m_tmo, m_done} & m_irqen);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] m);
    return 4'b0001 << m;
  endfunction

  task automatic model_reset();
    m_mode = '0; m_addr = '0; m_timeout = '0; m_irqen = '0; m_result = '0;
    m_done = 1'b0; m_tmo = 1'b0; m_abt = 1'b0; m_runs = '0; m_cycles = '0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic csr_write(input logic [3:0] r, input logic [31:0] d);
    csr_a  = {BANK, 6'd0, r};
    csr_we = 1'b1;
    csr_di = d;
    tick();
    csr_we = 1'b0;
    csr_di = '0;
  endtask

  task automatic csr_read(input logic [3:0] r, output logic [31:0] d);
    csr_a  = {BANK, 6'd0, r};
    csr_we = 1'b0;
    tick();
    d = csr_do;
  endtask

  // Select a mode and issue start from IDLE; returns with the FSM in START.
  task automatic start_run(input logic [1:0] mode);
    csr_write(4'd1, {30'd0, mode});
    m_mode = mode;
    csr_write(4'd0, 32'd1);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    sys_rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({cmode, cstart, cabort, caddr, irq, csr_do} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got cmode=%h cstart=%h cabort=%h caddr=%h irq=%b csr_do=%h expected all 0",
               cmode, cstart, cabort, caddr, irq, csr_do);
    end
    sys_rst = 1'b0;
    model_reset();
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL reset_status: got %h expected %h", rd, exp_status(1'b0)); end
    csr_read(4'd0, rd);
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h expected 0", rd); end
    csr_read(4'd8, rd);
    n_tests++;
    if (rd !== m_runs) begin n_fail++; $display("[TB] FAIL reset_runs: got %h expected %h", rd, m_runs); end
  endtask

  task automatic test_csr_map();
    logic [31:0] rd;
    logic [3:0]  unm;
    for (int i = 0; i < 3; i++) begin
      m_mode    = 2'($urandom_range(1, 3));
      m_addr    = {32'($urandom), 32'($urandom)};
      m_timeout = 32'($urandom);
      m_irqen   = 3'($urandom_range(0, 7));
      csr_write(4'd1, {30'd0, m_mode});
      csr_write(4'd2, m_addr[31:0]);
      csr_write(4'd3, m_addr[63:32]);
      csr_write(4'd4, m_timeout);
      csr_write(4'd6, {29'd0, m_irqen});
      csr_read(4'd1, rd);
      n_tests++;
      if (rd !== {30'd0, m_mode}) begin n_fail++; $display("[TB] FAIL mode_rb: got %h expected %h", rd, m_mode); end
      csr_read(4'd2, rd);
      n_tests++;
      if (rd !== m_addr[31:0]) begin n_fail++; $display("[TB] FAIL addr_lo_rb: got %h expected %h", rd, m_addr[31:0]); end
      csr_read(4'd3, rd);
      n_tests++;
      if (rd !== m_addr[63:32]) begin n_fail++; $display("[TB] FAIL addr_hi_rb: got %h expected %h", rd, m_addr[63:32]); end
      csr_read(4'd4, rd);
      n_tests++;
      if (rd !== m_timeout) begin n_fail++; $display("[TB] FAIL timeout_rb: got %h expected %h", rd, m_timeout); end
      csr_read(4'd6, rd);
      n_tests++;
      if (rd !== {29'd0, m_irqen}) begin n_fail++; $display("[TB] FAIL irqen_rb: got %h expected %h", rd, m_irqen); end
      // Write to another bank must not land; read from another bank returns 0.
      csr_a  = {4'h7, 6'd0, 4'd1};
      csr_we = 1'b1;
      csr_di = {30'd0, ~m_mode};
      tick();
      csr_we = 1'b0;
      csr_a  = {4'h9, 6'd0, 4'd1};
      tick();
      n_tests++;
      if (csr_do !== 32'd0) begin n_fail++; $display("[TB] FAIL unselected_read: got %h expected 0", csr_do); end
      csr_read(4'd1, rd);
      n_tests++;
      if (rd !== {30'd0, m_mode}) begin n_fail++; $display("[TB] FAIL other_bank_write: got %h expected %h", rd, m_mode); end
      unm = 4'($urandom_range(9, 15));
      csr_read(unm, rd);
      n_tests++;
      if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL unmapped_read: reg %0d got %h expected 0", unm, rd); end
    end
    m_timeout = '0;
    m_irqen   = '0;
    csr_write(4'd4, 32'd0);
    csr_write(4'd6, 32'd0);
  endtask

  task automatic test_end_run();
    logic [31:0] rd;
    logic [1:0]  mode;
    logic [7:0]  rbyte;
    int          n, cs, ca, lane;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        mode = 2'd2; m_addr = 64'h1_0000_0040; rbyte = 8'hA5; n = 10;
      end else begin
        mode = 2'($urandom_range(0, 3)); m_addr = {32'($urandom), 32'($urandom)};
        rbyte = 8'($urandom_range(0, 255)); n = $urandom_range(1, 12);
      end
      csr_write(4'd2, m_addr[31:0]);
      csr_write(4'd3, m_addr[63:32]);
      cs = cstart_pulses; ca = cabort_pulses;
      start_run(mode);
      n_tests++;
      if (cstart !== onehot(mode)) begin n_fail++; $display("[TB] FAIL cstart_value: got %b expected %b", cstart, onehot(mode)); end
      n_tests++;
      if (cmode !== mode || caddr !== m_addr) begin
        n_fail++; $display("[TB] FAIL run_target: got cmode=%h caddr=%h expected %h %h", cmode, caddr, mode, m_addr);
      end
      tick();
      n_tests++;
      if (cstart !== 4'd0) begin n_fail++; $display("[TB] FAIL cstart_width: got %b expected 0000", cstart); end
      repeat (n - 1) tick();
      lane  = int'(mode);
      cctrl = 32'($urandom);
      cctrl[lane*8 +: 8] = rbyte;
      cend  = onehot(mode);
      tick();
      cend = '0; cctrl = '0;
      m_result = rbyte; m_done = 1'b1; m_runs = m_runs + 32'd1; m_cycles = 32'(n);
      tick();
      n_tests++;
      if (cstart_pulses - cs !== 1 || cabort_pulses - ca !== 0 || last_cstart !== onehot(mode)) begin
        n_fail++; $display("[TB] FAIL end_pulses: got start=%0d abort=%0d last=%b expected 1 0 %b",
                           cstart_pulses - cs, cabort_pulses - ca, last_cstart, onehot(mode));
      end
      csr_read(4'd5, rd);
      n_tests++;
      if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL end_status: got %h expected %h", rd, exp_status(1'b0)); end
      csr_read(4'd7, rd);
      n_tests++;
      if (rd !== m_cycles) begin n_fail++; $display("[TB] FAIL end_cycles: got %0d expected %0d", rd, m_cycles); end
      csr_read(4'd8, rd);
      n_tests++;
      if (rd !== m_runs) begin n_fail++; $display("[TB] FAIL end_runs: got %0d expected %0d", rd, m_runs); end
      csr_a = {4'h3, 6'd0, 4'd5};
      tick();
      n_tests++;
      if (csr_do !== 32'd0) begin n_fail++; $display("[TB] FAIL unselected_status: got %h expected 0", csr_do); end
      csr_write(4'd5, 32'h100);
      m_done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    logic [1:0]  mode;
    int          t, ca;
    m_irqen = 3'b010;
    csr_write(4'd6, {29'd0, m_irqen});
    for (int it = 0; it < 2; it++) begin
      t = $urandom_range(3, 8);
      m_timeout = 32'(t);
      csr_write(4'd4, m_timeout);
      mode = 2'($urandom_range(0, 3));
      ca = cabort_pulses;
      start_run(mode);
      tick();
      repeat (t - 1) tick();
      n_tests++;
      if (irq !== exp_irq() || cabort !== 4'd0) begin
        n_fail++; $display("[TB] FAIL timeout_early: got irq=%b cabort=%b expected %b 0000", irq, cabort, exp_irq());
      end
      if (it == 0) tick();
      else csr_write(4'd5, 32'h200);
      m_tmo = 1'b1; m_cycles = m_timeout;
      n_tests++;
      if (cabort !== onehot(mode) || irq !== exp_irq()) begin
        n_fail++; $display("[TB] FAIL timeout_fire: got cabort=%b irq=%b expected %b %b", cabort, irq, onehot(mode), exp_irq());
      end
      tick();
      n_tests++;
      if (cabort_pulses - ca !== 1) begin n_fail++; $display("[TB] FAIL timeout_abort_width: got %0d expected 1", cabort_pulses - ca); end
      csr_read(4'd5, rd);
      n_tests++;
      if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL timeout_status: got %h expected %h", rd, exp_status(1'b0)); end
      csr_read(4'd7, rd);
      n_tests++;
      if (rd !== m_cycles) begin n_fail++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", rd, m_cycles); end
      csr_write(4'd5, 32'h200);
      m_tmo = 1'b0;
      n_tests++;
      if (irq !== exp_irq()) begin n_fail++; $display("[TB] FAIL timeout_w1c_irq: got %b expected %b", irq, exp_irq()); end
    end
    m_timeout = '0;
    csr_write(4'd4, 32'd0);
  endtask

  task automatic test_wrong_channel_abort();
    logic [31:0] rd;
    logic [1:0]  mode, other;
    int          ca, cs;
    mode  = 2'($urandom_range(0, 3));
    other = 2'(mode + 2'($urandom_range(1, 3)));
    cs = cstart_pulses; ca = cabort_pulses;
    start_run(mode);
    tick();
    cend  = onehot(other);
    cctrl = 32'($urandom);
    repeat ($urandom_range(3, 5)) tick();
    cend = '0; cctrl = '0;
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b1)) begin n_fail++; $display("[TB] FAIL wrong_cend_busy: got %h expected %h", rd, exp_status(1'b1)); end
    csr_write(4'd0, 32'd2);
    m_abt = 1'b1;
    n_tests++;
    if (cabort !== onehot(mode)) begin n_fail++; $display("[TB] FAIL abort_pulse: got %b expected %b", cabort, onehot(mode)); end
    tick();
    n_tests++;
    if (cabort_pulses - ca !== 1 || cstart_pulses - cs !== 1) begin
      n_fail++; $display("[TB] FAIL abort_counts: got abort=%0d start=%0d expected 1 1", cabort_pulses - ca, cstart_pulses - cs);
    end
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL abort_status: got %h expected %h", rd, exp_status(1'b0)); end
    csr_read(4'd8, rd);
    n_tests++;
    if (rd !== m_runs) begin n_fail++; $display("[TB] FAIL abort_runs: got %0d expected %0d", rd, m_runs); end
    csr_write(4'd5, 32'h400);
    m_abt = 1'b0;
  endtask

  task automatic test_busy_writes();
    logic [31:0] rd;
    logic [1:0]  mode;
    logic [7:0]  rbyte;
    int          cs, lane;
    mode = 2'($urandom_range(0, 3));
    cs = cstart_pulses;
    start_run(mode);
    tick();
    // RUN cycles 1..4: writes that must be ignored while busy.
    csr_write(4'd1, {30'd0, 2'(mode + 2'd1)});
    csr_write(4'd0, 32'd1);
    csr_write(4'd4, 32'd5);
    csr_write(4'd2, ~m_addr[31:0]);
    // RUN cycles 5..6.
    csr_read(4'd1, rd);
    n_tests++;
    if (rd !== {30'd0, m_mode}) begin n_fail++; $display("[TB] FAIL busy_mode: got %h expected %h", rd, m_mode); end
    csr_read(4'd4, rd);
    n_tests++;
    if (rd !== m_timeout) begin n_fail++; $display("[TB] FAIL busy_timeout: got %h expected %h", rd, m_timeout); end
    // RUN cycle 7 completes the run.
    rbyte = 8'($urandom_range(0, 255));
    lane  = int'(mode);
    cctrl = 32'($urandom);
    cctrl[lane*8 +: 8] = rbyte;
    cend  = onehot(mode);
    tick();
    cend = '0; cctrl = '0;
    m_result = rbyte; m_done = 1'b1; m_runs = m_runs + 32'd1; m_cycles = 32'd7;
    tick();
    n_tests++;
    if (cstart_pulses - cs !== 1) begin n_fail++; $display("[TB] FAIL busy_restart: got %0d start pulses expected 1", cstart_pulses - cs); end
    n_tests++;
    if (cmode !== mode || caddr !== m_addr) begin
      n_fail++; $display("[TB] FAIL busy_target: got cmode=%h caddr=%h expected %h %h", cmode, caddr, mode, m_addr);
    end
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL busy_status: got %h expected %h", rd, exp_status(1'b0)); end
    csr_read(4'd7, rd);
    n_tests++;
    if (rd !== m_cycles) begin n_fail++; $display("[TB] FAIL busy_cycles: got %0d expected %0d", rd, m_cycles); end
    csr_write(4'd5, 32'h100);
    m_done = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    logic [1:0]  mode;
    logic [7:0]  rbyte;
    int          t, ca, cs, lane;
    t = $urandom_range(3, 8);
    m_timeout = 32'(t);
    csr_write(4'd4, m_timeout);
    mode = 2'($urandom_range(0, 3));
    ca = cabort_pulses;
    start_run(mode);
    tick();
    repeat (t - 1) tick();
    rbyte = 8'($urandom_range(0, 255));
    lane  = int'(mode);
    cctrl = 32'($urandom);
    cctrl[lane*8 +: 8] = rbyte;
    cend  = onehot(mode);
    tick();
    cend = '0; cctrl = '0;
    m_result = rbyte; m_done = 1'b1; m_runs = m_runs + 32'd1;
    tick();
    n_tests++;
    if (cabort_pulses - ca !== 0) begin n_fail++; $display("[TB] FAIL tie_no_abort: got %0d abort pulses expected 0", cabort_pulses - ca); end
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL tie_status: got %h expected %h", rd, exp_status(1'b0)); end
    csr_read(4'd8, rd);
    n_tests++;
    if (rd !== m_runs) begin n_fail++; $display("[TB] FAIL tie_runs: got %0d expected %0d", rd, m_runs); end
    m_timeout = '0;
    csr_write(4'd4, 32'd0);
    // Start and abort in one write: no run at all.
    cs = cstart_pulses;
    csr_write(4'd0, 32'd3);
    tick();
    tick();
    n_tests++;
    if (cstart_pulses - cs !== 0) begin n_fail++; $display("[TB] FAIL start_abort: got %0d start pulses expected 0", cstart_pulses - cs); end
    csr_read(4'd0, rd);
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL start_abort_state: got %h expected 0", rd); end
    // Abort issued while the start strobe is out.
    ca = cabort_pulses;
    start_run(mode);
    csr_write(4'd0, 32'd2);
    tick();
    tick();
    m_abt = 1'b1;
    n_tests++;
    if (cabort_pulses - ca !== 1 || last_cabort !== onehot(mode)) begin
      n_fail++; $display("[TB] FAIL start_phase_abort: got %0d pulses last=%b expected 1 %b", cabort_pulses - ca, last_cabort, onehot(mode));
    end
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL start_phase_status: got %h expected %h", rd, exp_status(1'b0)); end
    csr_write(4'd5, 32'h500);
    m_abt = 1'b0; m_done = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    int          ca;
    m_irqen = 3'b111;
    csr_write(4'd6, {29'd0, m_irqen});
    m_addr = {32'($urandom), 32'($urandom)} | 64'h1;
    csr_write(4'd2, m_addr[31:0]);
    csr_write(4'd3, m_addr[63:32]);
    start_run(2'($urandom_range(1, 3)));
    tick();
    repeat (3) tick();
    ca = cabort_pulses;
    sys_rst = 1'b1;
    tick();
    n_tests++;
    if ({cmode, cstart, cabort, caddr, irq, csr_do} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset: got cmode=%h cstart=%h cabort=%h caddr=%h irq=%b csr_do=%h expected all 0",
               cmode, cstart, cabort, caddr, irq, csr_do);
    end
    sys_rst = 1'b0;
    model_reset();
    tick();
    n_tests++;
    if (cabort_pulses - ca !== 0) begin n_fail++; $display("[TB] FAIL midrun_no_abort: got %0d pulses expected 0", cabort_pulses - ca); end
    csr_read(4'd5, rd);
    n_tests++;
    if (rd !== exp_status(1'b0)) begin n_fail++; $display("[TB] FAIL midrun_status: got %h expected %h", rd, exp_status(1'b0)); end
    csr_read(4'd8, rd);
    n_tests++;
    if (rd !== m_runs) begin n_fail++; $display("[TB] FAIL midrun_runs: got %0d expected %0d", rd, m_runs); end
    csr_read(4'd6, rd);
    n_tests++;
    if (rd !== {29'd0, m_irqen}) begin n_fail++; $display("[TB] FAIL midrun_irqen: got %h expected %h", rd, m_irqen); end
  endtask

  initial begin
    sys_rst = 1'b1;
    csr_a   = '0;
    csr_we  = 1'b0;
    csr_di  = '0;
    cend    = '0;
    cctrl   = '0;
    model_reset();
    test_reset();
    test_csr_map();
    test_end_run();
    test_timeout();
    test_wrong_channel_abort();
    test_busy_writes();
    test_same_cycle();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
